// File: rtl/mem_arbiter.sv
// mem_arbiter: memory front-end between the core and a single-ported,
// 32-bit, variable-latency backing memory.
//
// Each core step becomes up to three memory beats, issued in this order:
// a low data word, a high data word (64-bit accesses only), then the
// instruction fetch. When the last beat finishes, `ready` pulses for one
// cycle and the core may advance. A beat that waits TIMEOUT cycles without
// an ack is completed with zero data, and the sticky `err` flag is set.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   instradr            instruction fetch address (bits [1:0] ignored)
//   instr               fetched instruction, valid from one ready to the next
//   dataadr             data address (low AW bits used, bits [1:0] ignored)
//   writedata           store data
//   memread, memwrite   load request / store request (nonzero memwrite)
//   dword               64-bit access (only meaningful when N=64)
//   readdata            load result, same validity as instr
//   ready               one-cycle step-complete pulse
//   mreq, mwe           memory beat request / beat is a write
//   madr, mwdata        beat word address / beat write data
//   mrdata, mack        beat read data / beat acknowledge
//   err                 sticky beat-timeout flag
module mem_arbiter #(
   parameter int N       = 64,
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] instradr,
   output logic [31:0]   instr,
   input  logic [N-1:0]  dataadr,
   input  logic [N-1:0]  writedata,
   input  logic          memread,
   input  logic [1:0]    memwrite,
   input  logic          dword,
   output logic [N-1:0]  readdata,
   output logic          ready,
   output logic          mreq,
   output logic          mwe,
   output logic [AW-1:0] madr,
   output logic [31:0]   mwdata,
   input  logic [31:0]   mrdata,
   input  logic          mack,
   output logic          err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam bit WIDE_OK = (N == 64);

   typedef enum logic [2:0] {IDLE, DLO, DHI, IFETCH, DONE} state_t;

   state_t          state_reg, state_next;
   logic [AW-1:2]   iadr_reg;
   logic [AW-1:2]   dadr_reg;
   logic [N-1:0]    wdata_reg;
   logic            load_reg, store_reg, wide_reg;
   logic [31:0]     lo_reg, hi_reg;
   logic [31:0]     instr_reg;
   logic [N-1:0]    readdata_reg;
   logic [CW-1:0]   cnt_reg;
   logic            err_reg;

   logic            beat;
   logic            at_limit;
   logic            beat_done;
   logic [31:0]     beat_data;
   logic [31:0]     wdata_hi;
   logic [N-1:0]    load_result;

   // Address bits that never reach the memory side.
   logic            unused_adr_bits;
   assign unused_adr_bits = ^{instradr[1:0], dataadr[1:0]};

   generate
      if (N > AW) begin : g_adr_unused
         logic unused_adr_hi;
         assign unused_adr_hi = ^dataadr[N-1:AW];
      end

      // High data word exists only in the 64-bit configuration.
      if (N == 64) begin : g_wide
         assign wdata_hi    = wdata_reg[N-1:32];
         assign load_result = wide_reg ? {hi_reg, lo_reg} : {{(N-32){1'b0}}, lo_reg};
      end else begin : g_narrow
         assign wdata_hi    = 32'h0;
         assign load_result = lo_reg;
      end
   endgenerate

   assign beat      = (state_reg == DLO) || (state_reg == DHI) || (state_reg == IFETCH);
   assign at_limit  = (cnt_reg == CW'(TIMEOUT));
   // An ack in the limit cycle wins over the timeout.
   assign beat_done = beat && (mack || at_limit);
   assign beat_data = mack ? mrdata : 32'h0;

   // Memory-side outputs depend on state and snapshot registers only.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      mreq       = 1'b0;
      mwe        = 1'b0;
      madr       = '0;
      mwdata     = 32'h0;
      case (state_reg)
         IDLE: begin
            state_next = (memread || (memwrite != 2'b00)) ? DLO : IFETCH;
         end
         DLO: begin
            mreq   = 1'b1;
            mwe    = store_reg;
            madr   = {dadr_reg, 2'b00};
            mwdata = wdata_reg[31:0];
            if (beat_done) state_next = wide_reg ? DHI : IFETCH;
         end
         DHI: begin
            mreq   = 1'b1;
            mwe    = store_reg;
            madr   = {dadr_reg, 2'b00} + AW'(4);
            mwdata = wdata_hi;
            if (beat_done) state_next = IFETCH;
         end
         IFETCH: begin
            mreq = 1'b1;
            madr = {iadr_reg, 2'b00};
            if (beat_done) state_next = DONE;
         end
         DONE: begin
            ready      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         iadr_reg     <= '0;
         dadr_reg     <= '0;
         wdata_reg    <= '0;
         load_reg     <= 1'b0;
         store_reg    <= 1'b0;
         wide_reg     <= 1'b0;
         lo_reg       <= 32'h0;
         hi_reg       <= 32'h0;
         instr_reg    <= 32'h0;
         readdata_reg <= '0;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_reg == IDLE) begin
            iadr_reg  <= instradr[AW-1:2];
            dadr_reg  <= dataadr[AW-1:2];
            wdata_reg <= writedata;
            store_reg <= (memwrite != 2'b00);
            // A store takes priority over a simultaneous load.
            load_reg  <= memread && (memwrite == 2'b00);
            wide_reg  <= dword && WIDE_OK;
         end

         // Wait counter restarts on every beat boundary.
         if (beat && !beat_done) cnt_reg <= cnt_reg + CW'(1);
         else                    cnt_reg <= '0;

         if (beat && at_limit && !mack) err_reg <= 1'b1;

         if (beat_done) begin
            case (state_reg)
               DLO: if (load_reg) lo_reg <= beat_data;
               DHI: if (load_reg) hi_reg <= beat_data;
               IFETCH: begin
                  // Results become visible on the edge entering DONE.
                  instr_reg <= beat_data;
                  if (load_reg) readdata_reg <= load_result;
               end
               default: ;
            endcase
         end
      end
   end

   assign instr    = instr_reg;
   assign readdata = readdata_reg;
   assign err      = err_reg;

endmodule
